// File: rtl/enemy_fire_scheduler_if.sv
// enemy_fire_scheduler_if: game-side enables, tank/bullet status and fire-grant outputs
interface enemy_fire_scheduler_if #(parameter int N_TANK = 5);
  logic              game_run;
  logic [N_TANK-1:0] tank_exit;
  logic [N_TANK-1:0] bullet_exit;
  logic [N_TANK-1:0] shoot;
  logic [5:0]        bullet_counter;
  logic [2:0]        fire_idx;
  logic              busy;
  modport master (output game_run, tank_exit, bullet_exit, input shoot, bullet_counter, fire_idx, busy);
  modport slave (input game_run, tank_exit, bullet_exit, output shoot, bullet_counter, fire_idx, busy);
endinterface

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: cooldown-paced round-robin fire grants for enemy tanks
module enemy_fire_scheduler #(
  parameter int                N_TANK      = 5,
  parameter logic [N_TANK-1:0] PLAYER_MASK = 5'b01000,
  parameter int                COOLDOWN    = 60,
  parameter int                ACK_TIMEOUT = 4
) (
  input  logic                   clk_f,
  input  logic                   rst_n,
  enemy_fire_scheduler_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, COOL, SELECT, FIRE, WAIT_ACK} state_t;
  localparam logic [5:0] CD      = 6'(COOLDOWN);
  localparam logic [2:0] TO_LAST = 3'(ACK_TIMEOUT - 1);
  state_t            state, state_n;
  logic [5:0]        cnt, cnt_n, cnt_inc;
  logic [2:0]        idx, idx_n, sel, cand, tmo, tmo_n;
  logic [N_TANK-1:0] shoot, shoot_n, elig;
  logic              found, ack;
  assign elig               = bus.tank_exit & ~bus.bullet_exit & ~PLAYER_MASK;
  assign ack                = bus.bullet_exit[idx] | ~bus.tank_exit[idx];
  assign cnt_inc            = (cnt == CD) ? CD : cnt + 6'd1;
  assign bus.shoot          = shoot;
  assign bus.bullet_counter = cnt;
  assign bus.fire_idx       = idx;
  assign bus.busy           = (state == FIRE) || (state == WAIT_ACK);
  // Round-robin search for the first eligible tank after the last granted one
  always_comb begin
    found = 1'b0;
    sel   = idx;
    cand  = '0;
    for (int k = 1; k <= N_TANK; k++) begin
      cand = 3'((int'(idx) + k) % N_TANK);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end
  // Next-state and next-output logic; losing game_run overrides every state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    tmo_n   = tmo;
    shoot_n = '0;
    if (!bus.game_run) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = '0;
          state_n = COOL;
        end
        COOL: begin
          cnt_n   = cnt_inc;
          state_n = (cnt_inc == CD) ? SELECT : COOL;
        end
        SELECT: begin
          cnt_n = CD;
          if (found) begin
            state_n = FIRE;
            idx_n   = sel;
            shoot_n = {{(N_TANK-1){1'b0}}, 1'b1} << sel;
          end
        end
        FIRE: begin
          cnt_n   = CD;
          tmo_n   = '0;
          state_n = WAIT_ACK;
        end
        WAIT_ACK: begin
          cnt_n   = (ack || tmo == TO_LAST) ? 6'd0 : CD;
          state_n = (ack || tmo == TO_LAST) ? COOL : WAIT_ACK;
          tmo_n   = tmo + 3'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // State and registered outputs; reset points fire_idx at the last tank so the first search starts at tank 0
  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'(N_TANK - 1);
      tmo   <= '0;
      shoot <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      tmo   <= tmo_n;
      shoot <= shoot_n;
    end
  end
endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 Parameter N_TANK, default 5, number of tank slots (bit i = tank i in all vectors).
REQ-002 Parameter PLAYER_MASK, default 5'b01000, tanks never scheduled to fire (player-controlled).
REQ-003 Parameter COOLDOWN, default 60, cycles between consecutive fire grants; range 1..63.
REQ-004 Parameter ACK_TIMEOUT, default 4, cycles to wait for a granted bullet to appear.
REQ-005 clk_f  input  1  frame-rate game clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 game_run  input  1  level; 1 = scheduling enabled.
REQ-008 tank_exit  input  N_TANK  1 = tank alive.
REQ-009 bullet_exit  input  N_TANK  1 = that tank's bullet currently in flight.
REQ-010 shoot  output  N_TANK  one-hot fire grant, registered.
REQ-011 bullet_counter  output  6  cooldown count, 0..COOLDOWN; COOLDOWN = fire permitted.
REQ-012 fire_idx  output  3  index of last granted tank.
REQ-013 busy  output  1  1 while in FIRE or WAIT_ACK.

Function
REQ-014 FSM states SHALL be IDLE, COOL, SELECT, FIRE, WAIT_ACK, encoded in one registered state variable.
REQ-015 Eligible(i) SHALL be tank_exit[i] & ~bullet_exit[i] & ~PLAYER_MASK[i], evaluated combinationally each cycle.
REQ-016 IDLE: bullet_counter held 0, shoot 0; game_run=1 -> COOL next cycle.
REQ-017 COOL: bullet_counter increments by 1 per cycle, saturating at COOLDOWN; on the cycle it equals COOLDOWN -> SELECT.
REQ-018 SELECT: round-robin search starting at (fire_idx+1) mod N_TANK, wrapping, for first eligible tank; found -> FIRE with fire_idx updated; none eligible -> remain SELECT, counter held at COOLDOWN.
REQ-019 FIRE: shoot[fire_idx]=1 for exactly one cycle, bullet_counter held at COOLDOWN during that cycle; -> WAIT_ACK.
REQ-020 WAIT_ACK: bullet_exit[fire_idx]=1 or ACK_TIMEOUT cycles elapsed -> COOL with bullet_counter cleared to 0 on the transition.
REQ-021 Latency: counter reaching COOLDOWN in SELECT with an eligible tank SHALL give shoot asserted exactly 1 cycle later.
REQ-022 tank_exit[fire_idx] falling during WAIT_ACK SHALL end the wait next cycle (-> COOL).
REQ-023 game_run=0 in any state SHALL force IDLE next cycle, shoot=0, counter=0, fire_idx retained.
REQ-024 At most one shoot bit SHALL be 1 in any cycle; shoot SHALL never be 1 outside FIRE.
REQ-025 A tank ineligible in SELECT SHALL be skipped without stalling; eligibility changes during FIRE SHALL not cancel the issued pulse.
REQ-026 Timeout counter SHALL be 3 bits, cleared on entry to WAIT_ACK.

Reset
REQ-027 rst_n low SHALL immediately set state=IDLE, shoot=0, bullet_counter=0, fire_idx=N_TANK-1 (first grant searches from tank 0), busy=0, timeout counter=0.
REQ-028 Reset release mid-game SHALL restart from IDLE; no shoot pulse within COOLDOWN+1 cycles after game_run observed high.

Verification
REQ-029 Reset, game_run=1, tank_exit=5'b11111, bullet_exit=0 -> bullet_counter 0..60, shoot=5'b00001 at cycle 62, fire_idx=0.
REQ-030 Acknowledge bullet_exit[0] 1 cycle after grant; repeat -> grants order tanks 0,1,2,4,0 (tank 3 masked), each ≥62 cycles apart.
REQ-031 tank_exit=5'b01000 only player alive -> state stays SELECT, bullet_counter=60, shoot never asserted; raise tank_exit[2] -> shoot=5'b00100 next cycle.
REQ-032 Never acknowledge grant -> WAIT_ACK exits after 4 cycles, counter restarts at 0, next grant to following tank.
REQ-033 Drop game_run during WAIT_ACK -> IDLE next cycle, counter 0; re-raise -> full 60-cycle cooldown before next shoot.
REQ-034 Assert rst_n=0 asynchronously mid-FIRE -> shoot=0 in same cycle, fire_idx=4, first post-reset grant to tank 0.
